// File: rtl/spi_frame_rx_pkg.sv
// Shared constants, FSM encoding and end-of-burst status type for the SPI camera frame receiver.
package spi_frame_rx_pkg;

  localparam int unsigned FRAME_W         = 64;
  localparam int unsigned FRAME_H         = 64;
  localparam int unsigned DEF_FRAME_BYTES = FRAME_W * FRAME_H;
  localparam int unsigned DEF_CNT_W       = 13;
  localparam logic [7:0]  DEF_IDLE_TIMEOUT = 8'h3F;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_CLOSE  = 2'd2
  } state_t;

  typedef struct packed {
    logic frame_done;
    logic err_short;
    logic err_long;
  } close_status_t;

  // Exactly one status bit is raised, overrun taking priority over short.
  function automatic close_status_t close_eval(input logic over, input logic partial,
                                               input logic bytes_short);
    close_status_t s;
    s = '0;
    if (over) begin
      s.err_long = 1'b1;
    end else if (partial || bytes_short) begin
      s.err_short = 1'b1;
    end else begin
      s.frame_done = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/spi_frame_rx_sync_ff2.sv
// Two-flop synchronizer with synchronous active-high reset.
module sync_ff2 (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_frame_rx.sv
// Oversampled SPI mode-0 frame receiver: byte stream out plus one status pulse per burst.
module spi_frame_rx
  import spi_frame_rx_pkg::*;
#(
  parameter logic [7:0]  IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int unsigned FRAME_BYTES  = DEF_FRAME_BYTES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             BUSY,
  output logic [7:0]       DATA,
  output logic             VALID,
  output logic [CNT_W-1:0] BYTE_CNT,
  output logic             FRAME_DONE,
  output logic             ERR_SHORT,
  output logic             ERR_LONG
);

  localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(FRAME_BYTES);

  logic          sclk_s2, sclk_s3, mosi_s2;
  logic          sclk_rise, sclk_edge;
  state_t        state, state_n;
  logic          shift_en, byte_done, close_now;
  logic [7:0]    timer;
  logic [6:0]    shift;
  logic [2:0]    bit_cnt;
  logic          over;
  close_status_t status_q;

  sync_ff2 u_sync_sclk (.CLK(CLK), .RST(RST), .d(SCLK), .q(sclk_s2));
  sync_ff2 u_sync_mosi (.CLK(CLK), .RST(RST), .d(MOSI), .q(mosi_s2));

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_edge = sclk_s2 ^ sclk_s3;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and per-cycle qualifiers; an SCLK edge always beats the timeout.
  always_comb begin
    state_n   = state;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    close_now = 1'b0;
    case (state)
      S_IDLE: begin
        if (sclk_rise) state_n = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!sclk_edge && (timer == IDLE_TIMEOUT)) begin
          state_n   = S_CLOSE;
          close_now = 1'b1;
        end
      end
      S_CLOSE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    shift_en  = sclk_rise && (state != S_CLOSE);
    byte_done = shift_en && (bit_cnt == 3'd7);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_s3  <= 1'b0;
      timer    <= 8'd0;
      shift    <= 7'd0;
      bit_cnt  <= 3'd0;
      over     <= 1'b0;
      BUSY     <= 1'b0;
      DATA     <= 8'd0;
      VALID    <= 1'b0;
      BYTE_CNT <= '0;
      status_q <= '0;
    end else begin
      sclk_s3  <= sclk_s2;
      BUSY     <= (state_n == S_ACTIVE);
      VALID    <= 1'b0;
      status_q <= '0;
      timer    <= ((state == S_ACTIVE) && !sclk_edge) ? timer + 8'd1 : 8'd0;
      if (shift_en) begin
        shift   <= {shift[5:0], mosi_s2};
        bit_cnt <= bit_cnt + 3'd1;
      end
      // Bytes past a full frame are dropped and only flagged.
      if (byte_done) begin
        if (BYTE_CNT < FRAME_MAX) begin
          DATA     <= {shift, mosi_s2};
          VALID    <= 1'b1;
          BYTE_CNT <= BYTE_CNT + CNT_W'(1);
        end else begin
          over <= 1'b1;
        end
      end
      if (close_now) begin
        status_q <= close_eval(over, bit_cnt != 3'd0, BYTE_CNT < FRAME_MAX);
      end
      if (state == S_CLOSE) begin
        bit_cnt  <= 3'd0;
        over     <= 1'b0;
        BYTE_CNT <= '0;
      end
    end
  end

  assign FRAME_DONE = status_q.frame_done;
  assign ERR_SHORT  = status_q.err_short;
  assign ERR_LONG   = status_q.err_long;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx with a shortened frame length.
module tb_spi_frame_rx;

  localparam int unsigned TB_FRAME = 256;
  localparam int unsigned CNT_W    = 13;
  localparam logic [7:0]  TO       = 8'h3F;

  logic             CLK, RST, SCLK, MOSI;
  logic             BUSY, VALID, FRAME_DONE, ERR_SHORT, ERR_LONG;
  logic [7:0]       DATA;
  logic [CNT_W-1:0] BYTE_CNT;

  int n_checks = 0;
  int n_pass   = 0;
  int vcount   = 0;
  int order_err = 0;
  int close_cnt = 0;
  int bidx      = 0;

  spi_frame_rx #(.IDLE_TIMEOUT(TO), .FRAME_BYTES(TB_FRAME), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .MOSI(MOSI), .BUSY(BUSY), .DATA(DATA),
    .VALID(VALID), .BYTE_CNT(BYTE_CNT), .FRAME_DONE(FRAME_DONE),
    .ERR_SHORT(ERR_SHORT), .ERR_LONG(ERR_LONG)
  );

  initial CLK = 1'b0;
  always #2 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Per-burst byte order tracking and status pulse counting.
  always @(negedge CLK) begin
    if (FRAME_DONE || ERR_SHORT || ERR_LONG) close_cnt++;
    if (!BUSY) bidx = 0;
    else if (VALID) begin
      if (DATA !== bidx[7:0]) order_err++;
      bidx++;
      vcount++;
    end
  end

  task automatic sclk_bit(input logic b, input int lo, input int hi);
    MOSI = b;
    repeat (lo) @(negedge CLK);
    SCLK = 1'b1;
    repeat (hi) @(negedge CLK);
    SCLK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int half);
    for (int i = 7; i >= 0; i--) sclk_bit(b[i], half, half);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge CLK);
      cyc++;
      if (VALID) break;
    end
  endtask

  task automatic wait_close(output int cyc, output logic [2:0] p);
    cyc = 0;
    p   = 3'b000;
    while (cyc < 1000) begin
      @(negedge CLK);
      cyc++;
      p = {FRAME_DONE, ERR_SHORT, ERR_LONG};
      if (p != 3'b000) break;
    end
  endtask

  initial begin
    int cyc, v0, e0, c0;
    logic [2:0] p;
    RST = 1'b1; SCLK = 1'b0; MOSI = 1'b0;

    // Reset held with SCLK toggling.
    repeat (4) @(negedge CLK) SCLK = ~SCLK;
    check("rst_busy", BUSY, 0);
    check("rst_valid", VALID, 0);
    check("rst_data", DATA, 0);
    check("rst_cnt", BYTE_CNT, 0);
    check("rst_pulses", {FRAME_DONE, ERR_SHORT, ERR_LONG}, 0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("post_rst_busy", BUSY, 0);

    // Single byte 0xA5 at CLK/8, latency from the 8th raw rise.
    for (int i = 7; i >= 1; i--) sclk_bit(1'(8'hA5 >> i), 4, 4);
    MOSI = 1'b1;
    repeat (4) @(negedge CLK);
    SCLK = 1'b1;
    wait_valid(cyc);
    check("a5_latency", cyc, 3);
    check("a5_data", DATA, 8'hA5);
    check("a5_cnt", BYTE_CNT, 1);
    check("a5_busy", BUSY, 1);
    @(negedge CLK);
    SCLK = 1'b0;
    wait_close(cyc, p);
    check("a5_close_delay", cyc, 32'(TO) + 4);
    check("a5_pulse", p, 3'b010);
    check("a5_close_busy", BUSY, 0);
    check("a5_close_cnt", BYTE_CNT, 1);
    @(negedge CLK);
    check("a5_idle_cnt", BYTE_CNT, 0);
    check("a5_data_hold", DATA, 8'hA5);

    // Full frame, byte[i] = i.
    v0 = vcount; e0 = order_err;
    for (int i = 0; i < TB_FRAME; i++) send_byte(8'(i), 3);
    wait_close(cyc, p);
    check("frame_pulse", p, 3'b100);
    check("frame_cnt_close", BYTE_CNT, TB_FRAME);
    check("frame_valids", vcount - v0, TB_FRAME);
    check("frame_order", order_err - e0, 0);
    @(negedge CLK);
    check("frame_cnt_idle", BYTE_CNT, 0);
    repeat (4) @(negedge CLK);

    // Overrun by one byte.
    v0 = vcount; e0 = order_err;
    for (int i = 0; i <= TB_FRAME; i++) send_byte(8'(i), 3);
    check("over_cnt_sat", BYTE_CNT, TB_FRAME);
    check("over_data", DATA, 8'hFF);
    wait_close(cyc, p);
    check("over_pulse", p, 3'b001);
    check("over_valids", vcount - v0, TB_FRAME);
    check("over_order", order_err - e0, 0);
    repeat (4) @(negedge CLK);

    // Full frame plus three stray bits.
    v0 = vcount;
    for (int i = 0; i < TB_FRAME; i++) send_byte(8'(i), 3);
    sclk_bit(1'b1, 3, 3); sclk_bit(1'b0, 3, 3); sclk_bit(1'b1, 3, 3);
    wait_close(cyc, p);
    check("partial_pulse", p, 3'b010);
    check("partial_valids", vcount - v0, TB_FRAME);
    repeat (4) @(negedge CLK);

    // Mid-byte SCLK gap one short of the timeout.
    c0 = close_cnt;
    for (int i = 7; i >= 4; i--) sclk_bit(1'(8'h5A >> i), 4, 4);
    sclk_bit(1'(8'h5A >> 3), 32'(TO) - 1, 4);
    for (int i = 2; i >= 1; i--) sclk_bit(1'(8'h5A >> i), 4, 4);
    MOSI = 1'b0;
    repeat (4) @(negedge CLK);
    SCLK = 1'b1;
    wait_valid(cyc);
    check("gap_valid", VALID, 1);
    check("gap_data", DATA, 8'h5A);
    check("gap_busy", BUSY, 1);
    check("gap_no_close", close_cnt - c0, 0);
    @(negedge CLK);
    SCLK = 1'b0;
    wait_close(cyc, p);
    check("gap_pulse", p, 3'b010);
    repeat (4) @(negedge CLK);

    // Reset in the middle of a byte, then a fresh burst.
    for (int i = 7; i >= 4; i--) sclk_bit(1'(8'hF0 >> i), 4, 4);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    c0 = close_cnt;
    @(negedge CLK);
    check("mrst_busy", BUSY, 0);
    check("mrst_cnt", BYTE_CNT, 0);
    repeat (32'(TO) + 10) @(negedge CLK);
    check("mrst_no_pulse", close_cnt - c0, 0);
    for (int i = 7; i >= 1; i--) sclk_bit(1'(8'h3C >> i), 4, 4);
    MOSI = 1'b0;
    repeat (4) @(negedge CLK);
    SCLK = 1'b1;
    wait_valid(cyc);
    check("mrst_data", DATA, 8'h3C);
    check("mrst_new_cnt", BYTE_CNT, 1);
    @(negedge CLK);
    SCLK = 1'b0;
    wait_close(cyc, p);
    check("mrst_pulse", p, 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
